// File: rtl/spi_ram_pkg.sv
// Shared constants, command codes and FSM state type for the SPI-RAM subsystem.
package spi_ram_pkg;

    localparam int WORD_W = 10;
    localparam int DATA_W = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } spi_state_e;

endpackage

// File: rtl/spi_tx_serializer.sv
// Load-on-strobe MSB-first shifter that drives MISO for one read-data byte.
// abort_i (slave select high) drops the shift and forces MISO low.
module spi_tx_serializer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              abort_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              busy_o,
    output logic              miso_o
);
    localparam int CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic              busy_q, busy_d;
    logic              miso_q, miso_d;

    // The MSB goes straight to MISO on load; rem counts the bits still queued.
    always_comb begin
        sreg_d = sreg_q;
        rem_d  = rem_q;
        busy_d = busy_q;
        miso_d = miso_q;
        if (abort_i) begin
            busy_d = 1'b0;
            miso_d = 1'b0;
            rem_d  = '0;
        end else if (load_i && !busy_q) begin
            busy_d = 1'b1;
            miso_d = data_i[DATA_W-1];
            sreg_d = {data_i[DATA_W-2:0], 1'b0};
            rem_d  = CNT_W'(DATA_W - 1);
        end else if (busy_q) begin
            if (rem_q != '0) begin
                miso_d = sreg_q[DATA_W-1];
                sreg_d = sreg_q << 1;
                rem_d  = rem_q - CNT_W'(1);
            end else begin
                miso_d = 1'b0;
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
            rem_q  <= '0;
            busy_q <= 1'b0;
            miso_q <= 1'b0;
        end else begin
            sreg_q <= sreg_d;
            rem_q  <= rem_d;
            busy_q <= busy_d;
            miso_q <= miso_d;
        end
    end

    assign busy_o = busy_q;
    assign miso_o = miso_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave front end: deserialises 10-bit command/data words and returns read data on MISO.
// Define SPI_SLAVE_SVA_EN to compile in the embedded protocol assertions.
module spi_slave #(
    parameter int WORD_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);
    import spi_ram_pkg::*;

    localparam int CNT_W = $clog2(WORD_W + 1);

    spi_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [WORD_W-2:0] shift_q;
    logic [WORD_W-1:0] rx_data_q;
    logic              rx_valid_q;
    logic              rd_addr_done_q;
    logic              tx_wait_q;
    logic              tx_busy;
    logic              tx_load;

    assign tx_load = tx_wait_q && tx_valid && !tx_busy && !SS_n && (state_q == READ_DATA);

    // Frame FSM: the counter saturates at WORD_W so trailing bits in a long frame are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            shift_q        <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_done_q <= 1'b0;
            tx_wait_q      <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (SS_n) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                tx_wait_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: state_q <= CHK_CMD;
                    CHK_CMD: begin
                        shift_q <= {shift_q[WORD_W-3:0], MOSI};
                        cnt_q   <= CNT_W'(1);
                        if (!MOSI)               state_q <= WRITE;
                        else if (rd_addr_done_q) state_q <= READ_DATA;
                        else                     state_q <= READ_ADD;
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (cnt_q != CNT_W'(WORD_W)) begin
                            shift_q <= {shift_q[WORD_W-3:0], MOSI};
                            cnt_q   <= cnt_q + CNT_W'(1);
                            if (cnt_q == CNT_W'(WORD_W - 1)) begin
                                rx_data_q  <= {shift_q, MOSI};
                                rx_valid_q <= 1'b1;
                                if (state_q == READ_ADD) rd_addr_done_q <= 1'b1;
                                if (state_q == READ_DATA) begin
                                    rd_addr_done_q <= 1'b0;
                                    tx_wait_q      <= 1'b1;
                                end
                            end
                        end
                        if (tx_load) tx_wait_q <= 1'b0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    spi_tx_serializer #(.DATA_W(DATA_W)) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .abort_i (SS_n),
        .load_i  (tx_load),
        .data_i  (tx_data),
        .busy_o  (tx_busy),
        .miso_o  (MISO)
    );

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

`ifdef SPI_SLAVE_SVA_EN
    a_rx_valid_single: assert property (@(posedge clk) disable iff (!rst_n)
        rx_valid_q |=> !rx_valid_q);
    a_rx_valid_cause: assert property (@(posedge clk) disable iff (!rst_n)
        rx_valid_q |-> $past(!SS_n && (cnt_q == CNT_W'(WORD_W - 1)) &&
                             (state_q inside {WRITE, READ_ADD, READ_DATA})));
    a_miso_idle: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == IDLE) |-> !MISO);
    a_state_legal: assert property (@(posedge clk) disable iff (!rst_n)
        state_q inside {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA});
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: received words are checked through a scoreboard queue,
// MISO read-back and internal read-address tracking are checked at fixed edges.
module tb_spi_slave;
    import spi_ram_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       SS_n = 1'b1;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;

    int         compared = 0;
    int         mismatched = 0;
    int         rxPulses = 0;
    int         p0;
    logic [9:0] expQ[$];
    logic [9:0] expWord;
    logic [7:0] txByte;

    spi_slave #(.WORD_W(10), .DATA_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    // Single compare point: every check funnels through this assertion
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard sink: each rx_valid pulse pops one expected word
    always @(negedge clk) begin
        if (rst_n && rx_valid) begin
            rxPulses++;
            if (expQ.size() == 0) begin
                checkOutput("rx_valid unexpected", {31'd0, rx_valid}, 32'd0);
            end else begin
                expWord = expQ.pop_front();
                checkOutput("rx_data", {22'd0, rx_data}, {22'd0, expWord});
            end
        end
    end

    // Starts a frame and shifts n bits MSB-first; returns at the negedge after the last sampling edge
    task automatic applyStimulus(input logic [15:0] bits, input int n);
        @(negedge clk);
        SS_n = 1'b0;
        MOSI = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) checkOutput("state after E0", {29'd0, dut.state_q}, {29'd0, CHK_CMD});
            MOSI = bits[n-1-i];
        end
        @(negedge clk);
        MOSI = 1'b0;
    endtask

    // Raises SS_n and checks the frame produced the required number of strobes
    task automatic endFrame(input string tag, input int expPulses);
        SS_n = 1'b1;
        @(negedge clk);
        checkOutput({tag, " pulses"}, rxPulses - p0, expPulses);
        checkOutput({tag, " miso idle"}, {31'd0, MISO}, 32'd0);
        checkOutput({tag, " state idle"}, {29'd0, dut.state_q}, {29'd0, IDLE});
    endtask

    task automatic runFrame(input string tag, input logic [9:0] word);
        p0 = rxPulses;
        expQ.push_back(word);
        applyStimulus({6'd0, word}, 10);
        endFrame(tag, 1);
    endtask

    initial begin
        $display("[TB] start");
        #1;
        checkOutput("reset miso", {31'd0, MISO}, 32'd0);
        checkOutput("reset rx_data", {22'd0, rx_data}, 32'd0);
        checkOutput("reset rx_valid", {31'd0, rx_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Write frame, MISO must stay low throughout
        p0 = rxPulses;
        expQ.push_back(10'h0A5);
        applyStimulus({6'd0, CMD_WR_ADDR, 8'hA5}, 10);
        checkOutput("write miso", {31'd0, MISO}, 32'd0);
        endFrame("write", 1);

        // Read-address then read-data with RAM response 8'hC3
        runFrame("rdaddr", {CMD_RD_ADDR, 8'h3C});
        checkOutput("rd_addr_done set", {31'd0, dut.rd_addr_done_q}, 32'd1);

        p0 = rxPulses;
        expQ.push_back({CMD_RD_DATA, 8'h56});
        applyStimulus({6'd0, CMD_RD_DATA, 8'h56}, 10);
        checkOutput("rddata state", {29'd0, dut.state_q}, {29'd0, READ_DATA});
        checkOutput("rd_addr_done clr", {31'd0, dut.rd_addr_done_q}, 32'd0);
        @(negedge clk);
        checkOutput("miso before load", {31'd0, MISO}, 32'd0);
        txByte   = 8'hC3;
        tx_data  = txByte;
        tx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tx_valid = 1'b0;
            checkOutput("miso bit", {31'd0, MISO}, {31'd0, txByte[7-i]});
        end
        @(negedge clk);
        checkOutput("miso after E20", {31'd0, MISO}, 32'd0);
        endFrame("rddata", 1);

        // Read command with rd_addr_done clear goes to READ_ADD; tx_valid there is ignored
        p0 = rxPulses;
        expQ.push_back(10'h3AA);
        applyStimulus(16'h03AA, 10);
        checkOutput("second read state", {29'd0, dut.state_q}, {29'd0, READ_ADD});
        @(negedge clk);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("readadd miso", {31'd0, MISO}, 32'd0);
        end
        endFrame("readadd", 1);
        checkOutput("rd_addr_done set2", {31'd0, dut.rd_addr_done_q}, 32'd1);

        // Asynchronous reset mid-frame after 5 bits
        p0 = rxPulses;
        applyStimulus(16'h0017, 5);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst miso", {31'd0, MISO}, 32'd0);
        checkOutput("midrst rx_data", {22'd0, rx_data}, 32'd0);
        checkOutput("midrst rx_valid", {31'd0, rx_valid}, 32'd0);
        checkOutput("midrst rd_addr_done", {31'd0, dut.rd_addr_done_q}, 32'd0);
        SS_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midrst pulses", rxPulses - p0, 0);

        p0 = rxPulses;
        expQ.push_back(10'h2AB);
        applyStimulus(16'h02AB, 10);
        checkOutput("post reset read state", {29'd0, dut.state_q}, {29'd0, READ_ADD});
        endFrame("postrst", 1);

        // Aborted write frame after 6 bits, then a full write
        p0 = rxPulses;
        applyStimulus(16'h000F, 6);
        endFrame("abort", 0);
        runFrame("wrdata", {CMD_WR_DATA, 8'hF0});
        checkOutput("rd_addr_done kept", {31'd0, dut.rd_addr_done_q}, 32'd1);

        // 14-bit frame: only the first 10 bits form a word
        p0 = rxPulses;
        expQ.push_back(10'h0C3);
        applyStimulus(16'h0C3F, 14);
        endFrame("long", 1);
        checkOutput("rx_data held", {22'd0, rx_data}, 32'h0C3);
        checkOutput("scoreboard drained", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
